// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg
//   Shared definitions for the immediate-generation stage: RV base opcodes,
//   shift funct3 encodings and the format classification codes.
package imm_gen_pipe_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    // funct3 values of the immediate shifts (SLLI, SRLI/SRAI)
    localparam logic [2:0] F3Sll = 3'b001;
    localparam logic [2:0] F3Sr  = 3'b101;

    localparam int unsigned FMT_W = 3;

    // Code 7 is reserved and never produced.
    typedef enum logic [FMT_W-1:0] {
        FmtNone  = 3'd0,
        FmtI     = 3'd1,
        FmtS     = 3'd2,
        FmtB     = 3'd3,
        FmtU     = 3'd4,
        FmtJ     = 3'd5,
        FmtShamt = 3'd6
    } fmt_e;

endpackage

// File: rtl/imm_gen_pipe_imm_decode_comb.sv
// imm_decode_comb
//   Purely combinational immediate extraction and format classification for
//   RV32I/RV64I instruction words.
// Ports:
//   inst_i  raw 32-bit instruction word
//   imm_o   XLEN-bit immediate (sign- or zero-extended per format)
//   fmt_o   format code
module imm_decode_comb
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned OFFSET_SHIFT = 0
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output fmt_e            fmt_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];

    // Size casts of signed operands sign-extend to XLEN.
    always_comb begin
        imm_o = '0;
        fmt_o = FmtNone;
        case (opcode)
            OpcLoad, OpcJalr: begin
                imm_o = XLEN'($signed(inst_i[31:20]));
                fmt_o = FmtI;
            end
            OpcOpImm: begin
                if (funct3 == F3Sll || funct3 == F3Sr) begin
                    // Shift amount only; funct7/funct6 bits are not part of the value.
                    if (XLEN == 64) begin
                        imm_o = XLEN'(inst_i[25:20]);
                    end else begin
                        imm_o = XLEN'(inst_i[24:20]);
                    end
                    fmt_o = FmtShamt;
                end else begin
                    imm_o = XLEN'($signed(inst_i[31:20]));
                    fmt_o = FmtI;
                end
            end
            OpcStore: begin
                imm_o = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
                fmt_o = FmtS;
            end
            OpcBranch: begin
                imm_o = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                       inst_i[11:8], 1'b0})) << OFFSET_SHIFT;
                fmt_o = FmtB;
            end
            OpcLui, OpcAuipc: begin
                imm_o = XLEN'($signed({inst_i[31:12], 12'b0}));
                fmt_o = FmtU;
            end
            OpcJal: begin
                imm_o = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                       inst_i[30:21], 1'b0})) << OFFSET_SHIFT;
                fmt_o = FmtJ;
            end
            default: begin
                imm_o = '0;
                fmt_o = FmtNone;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Registered immediate-generation stage. Decodes the incoming instruction
//   and holds results in a 2-entry skid buffer (entry 0 is the head).
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   flush                 drop all buffered entries (and any push this cycle)
//   in_valid/in_ready     input handshake; in_ready depends on state only
//   in_inst               raw instruction word
//   out_valid/out_ready   output handshake for the head entry
//   out_inst/out_imm/out_fmt  head entry contents
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned OFFSET_SHIFT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output logic [FMT_W-1:0] out_fmt
);

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;

    imm_decode_comb #(
        .XLEN        (XLEN),
        .OFFSET_SHIFT(OFFSET_SHIFT)
    ) u_decode (
        .inst_i(in_inst),
        .imm_o (dec_imm),
        .fmt_o (dec_fmt)
    );

    logic [1:0]      occ_q, occ_d;
    logic [31:0]     e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;
    logic [XLEN-1:0] e0_imm_q, e0_imm_d, e1_imm_q, e1_imm_d;
    fmt_e            e0_fmt_q, e0_fmt_d, e1_fmt_q, e1_fmt_d;

    logic push, pop;

    assign in_ready  = !reset && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_inst = e0_inst_q;
    assign out_imm  = e0_imm_q;
    assign out_fmt  = e0_fmt_q;

    always_comb begin
        occ_d     = occ_q;
        e0_inst_d = e0_inst_q;
        e0_imm_d  = e0_imm_q;
        e0_fmt_d  = e0_fmt_q;
        e1_inst_d = e1_inst_q;
        e1_imm_d  = e1_imm_q;
        e1_fmt_d  = e1_fmt_q;
        if (flush) begin
            // Payload registers keep their contents; only occupancy is cleared.
            occ_d = 2'd0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        e0_inst_d = in_inst;
                        e0_imm_d  = dec_imm;
                        e0_fmt_d  = dec_fmt;
                        occ_d     = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        e0_inst_d = in_inst;
                        e0_imm_d  = dec_imm;
                        e0_fmt_d  = dec_fmt;
                    end else if (push) begin
                        e1_inst_d = in_inst;
                        e1_imm_d  = dec_imm;
                        e1_fmt_d  = dec_fmt;
                        occ_d     = 2'd2;
                    end else if (pop) begin
                        occ_d = 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        e0_inst_d = e1_inst_q;
                        e0_imm_d  = e1_imm_q;
                        e0_fmt_d  = e1_fmt_q;
                        occ_d     = 2'd1;
                    end
                end
                default: occ_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q     <= 2'd0;
            e0_inst_q <= '0;
            e0_imm_q  <= '0;
            e0_fmt_q  <= FmtNone;
            e1_inst_q <= '0;
            e1_imm_q  <= '0;
            e1_fmt_q  <= FmtNone;
        end else begin
            occ_q     <= occ_d;
            e0_inst_q <= e0_inst_d;
            e0_imm_q  <= e0_imm_d;
            e0_fmt_q  <= e0_fmt_d;
            e1_inst_q <= e1_inst_d;
            e1_imm_q  <= e1_imm_d;
            e1_fmt_q  <= e1_fmt_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, XLEN=32 with
// OFFSET_SHIFT=1) share one stimulus stream and one FIFO reference model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic        out_ready = 1'b0;

    logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic [31:0] inst_a, inst_b, inst_c;
    logic [31:0] imm_a, imm_c;
    logic [63:0] imm_b;
    logic [2:0]  fmt_a, fmt_b, fmt_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .OFFSET_SHIFT(0)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
        .in_inst(in_inst), .out_valid(vld_a), .out_ready(out_ready), .out_inst(inst_a),
        .out_imm(imm_a), .out_fmt(fmt_a)
    );

    imm_gen_pipe #(.XLEN(64), .OFFSET_SHIFT(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
        .in_inst(in_inst), .out_valid(vld_b), .out_ready(out_ready), .out_inst(inst_b),
        .out_imm(imm_b), .out_fmt(fmt_b)
    );

    imm_gen_pipe #(.XLEN(32), .OFFSET_SHIFT(1)) dut_c (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
        .in_inst(in_inst), .out_valid(vld_c), .out_ready(out_ready), .out_inst(inst_c),
        .out_imm(imm_c), .out_fmt(fmt_c)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Format classification straight from the opcode table.
    function automatic int ref_fmt(input logic [31:0] w);
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        case (op)
            'h03, 'h67: return 1;
            'h13:       return (f3 == 1 || f3 == 5) ? 6 : 1;
            'h23:       return 2;
            'h63:       return 3;
            'h37, 'h17: return 4;
            'h6f:       return 5;
            default:    return 0;
        endcase
    endfunction

    // Immediate as a signed integer built by weighted field sums, then
    // truncated to the requested width.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input int xlen, input int sh);
        longint s, sgn, hi12, hi7, v;
        int fmt = ref_fmt(w);
        s    = longint'($signed(w));
        sgn  = s >>> 31;           // 0 or -1
        hi12 = s >>> 20;
        hi7  = s >>> 25;
        case (fmt)
            1: v = hi12;
            2: v = hi7 * 32 + longint'(w[11:7]);
            3: v = (sgn * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                    + longint'(w[11:8]) * 2) * (longint'(1) << sh);
            4: v = longint'($signed(w & 32'hFFFF_F000));
            5: v = (sgn * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                    + longint'(w[30:21]) * 2) * (longint'(1) << sh);
            6: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return 64'(v);
    endfunction

    // Reference FIFO, advanced at each rising edge.
    logic [31:0] q[$];
    bit started = 0;
    bit fresh   = 0;   // no push since the last reset

    always @(posedge clk) begin
        bit push, pop;
        if (reset) begin
            q.delete();
            started = 1;
            fresh   = 1;
        end else if (flush) begin
            q.delete();
        end else begin
            push = in_valid && (q.size() < 2);
            pop  = (q.size() > 0) && out_ready;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(in_inst);
                fresh = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic        exp_rdy, exp_vld;
            logic [31:0] hd;
            exp_rdy = !reset && (q.size() < 2);
            exp_vld = (q.size() > 0);
            chk("in_ready_x32", rdy_a, exp_rdy);
            chk("in_ready_x64", rdy_b, exp_rdy);
            chk("in_ready_sh1", rdy_c, exp_rdy);
            chk("out_valid_x32", vld_a, exp_vld);
            chk("out_valid_x64", vld_b, exp_vld);
            chk("out_valid_sh1", vld_c, exp_vld);
            if (exp_vld) begin
                hd = q[0];
                chk("out_inst_x32", inst_a, hd);
                chk("out_inst_x64", inst_b, hd);
                chk("out_inst_sh1", inst_c, hd);
                chk("out_imm_x32", imm_a, ref_imm(hd, 32, 0));
                chk("out_imm_x64", imm_b, ref_imm(hd, 64, 0));
                chk("out_imm_sh1", imm_c, ref_imm(hd, 32, 1));
                chk("out_fmt_x32", fmt_a, 64'(ref_fmt(hd)));
                chk("out_fmt_x64", fmt_b, 64'(ref_fmt(hd)));
                chk("out_fmt_sh1", fmt_c, 64'(ref_fmt(hd)));
            end else if (fresh && !reset) begin
                chk("rst_inst_x32", inst_a, 0);
                chk("rst_imm_x32", imm_a, 0);
                chk("rst_imm_x64", imm_b, 0);
                chk("rst_fmt_x32", fmt_a, 0);
                chk("rst_fmt_sh1", fmt_c, 0);
            end
        end
    end

    // Apply inputs for one rising edge, return 1 time unit after it.
    task automatic drive(input logic v, input logic [31:0] w, input logic ordy,
                         input logic fl);
        in_valid  = v;
        in_inst   = w;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    localparam int NDIR = 10;
    logic [31:0] dir_inst [NDIR] = '{
        32'hFFF00093, 32'hFE112E23, 32'hFE000CE3, 32'h123452B7, 32'h800002B7,
        32'h4030D093, 32'h0000007F, 32'hFF9FF0EF, 32'h00412083, 32'h000080E7
    };
    // Hand-computed XLEN=32/shift0 immediate and format for each vector.
    logic [31:0] dir_imm [NDIR] = '{
        32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h80000000,
        32'h00000003, 32'h00000000, 32'hFFFFFFF8, 32'h00000004, 32'h00000000
    };
    logic [2:0] dir_fmt [NDIR] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd0, 3'd5, 3'd1, 3'd1};

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("lit_rst_ready_low", rdy_a, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lit_ready_after_rst", rdy_a, 1);
        chk("lit_valid_after_rst", vld_a, 0);
        chk("lit_fmt_after_rst", fmt_a, 0);

        // Streaming with out_ready=1: each result appears one cycle later.
        for (int i = 0; i < NDIR; i++) begin
            drive(1'b1, dir_inst[i], 1'b1, 1'b0);
            chk("lit_stream_valid", vld_a, 1);
            chk("lit_stream_imm", imm_a, dir_imm[i]);
            chk("lit_stream_fmt", fmt_a, dir_fmt[i]);
            if (i == 2) chk("lit_beq_sh1", imm_c, 32'hFFFFFFF0);
            if (i == 4) chk("lit_lui_x64", imm_b, 64'hFFFFFFFF80000000);
            if (i == 5) chk("lit_srai_x64", imm_b, 64'd3);
            if (i == 7) chk("lit_jal_sh1", imm_c, 32'hFFFFFFF0);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lit_drained", vld_a, 0);

        // Backpressure: third offer must be held off.
        drive(1'b1, 32'h00100113, 1'b0, 1'b0);
        drive(1'b1, 32'h00200193, 1'b0, 1'b0);
        drive(1'b1, 32'h00300213, 1'b0, 1'b0);
        chk("lit_full_ready", rdy_a, 0);
        chk("lit_full_head", inst_a, 32'h00100113);
        drive(1'b1, 32'h00300213, 1'b0, 1'b0);
        chk("lit_stall_stable", inst_a, 32'h00100113);
        drive(1'b1, 32'h00300213, 1'b1, 1'b0);
        chk("lit_order_2", inst_a, 32'h00200193);
        drive(1'b1, 32'h00300213, 1'b1, 1'b0);
        chk("lit_order_3", inst_a, 32'h00300213);
        chk("lit_order_3_imm", imm_a, 32'd3);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lit_order_empty", vld_a, 0);

        // Flush with two buffered and a simultaneous push.
        drive(1'b1, 32'h00500293, 1'b0, 1'b0);
        drive(1'b1, 32'h00600313, 1'b0, 1'b0);
        drive(1'b1, 32'h00700393, 1'b1, 1'b1);
        chk("lit_flush_valid", vld_a, 0);
        chk("lit_flush_ready", rdy_a, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lit_flush_no_ghost", vld_a, 0);

        // Reset mid-stream (reset also wins over a flush/push in the same cycle).
        drive(1'b1, 32'hFFF00093, 1'b0, 1'b0);
        drive(1'b1, 32'hFE112E23, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, 32'h123452B7, 1'b1, 1'b1);
        chk("lit_midrst_ready", rdy_a, 0);
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("lit_midrst_valid", vld_a, 0);
        chk("lit_midrst_ready1", rdy_a, 1);
        chk("lit_midrst_imm", imm_a, 0);
        chk("lit_midrst_imm64", imm_b, 0);
        chk("lit_midrst_fmt", fmt_a, 0);

        // A couple more pushes after reset to make sure the stage recovers.
        drive(1'b1, 32'hFE000CE3, 1'b1, 1'b0);
        chk("lit_recover_imm", imm_a, 32'hFFFFFFF8);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
